// File: rtl/whack_pkg.sv
// Shared constants and types for the whack-a-mole hit/miss judge.
package whack_pkg;

    localparam int unsigned NUM_HOLES = 10;

    typedef logic [3:0] hole_t;

    // Top-row digit make codes, holes 0..9
    localparam logic [7:0] KeyRow0 = 8'h45;
    localparam logic [7:0] KeyRow1 = 8'h16;
    localparam logic [7:0] KeyRow2 = 8'h1E;
    localparam logic [7:0] KeyRow3 = 8'h26;
    localparam logic [7:0] KeyRow4 = 8'h25;
    localparam logic [7:0] KeyRow5 = 8'h2E;
    localparam logic [7:0] KeyRow6 = 8'h36;
    localparam logic [7:0] KeyRow7 = 8'h3D;
    localparam logic [7:0] KeyRow8 = 8'h3E;
    localparam logic [7:0] KeyRow9 = 8'h46;

    // Keypad digit make codes, holes 0..9
    localparam logic [7:0] KeyPad0 = 8'h70;
    localparam logic [7:0] KeyPad1 = 8'h69;
    localparam logic [7:0] KeyPad2 = 8'h72;
    localparam logic [7:0] KeyPad3 = 8'h7A;
    localparam logic [7:0] KeyPad4 = 8'h6B;
    localparam logic [7:0] KeyPad5 = 8'h73;
    localparam logic [7:0] KeyPad6 = 8'h74;
    localparam logic [7:0] KeyPad7 = 8'h6C;
    localparam logic [7:0] KeyPad8 = 8'h75;
    localparam logic [7:0] KeyPad9 = 8'h7D;

endpackage

// File: rtl/keycode_to_hole.sv
// Combinational PS/2 scan code to hole index decoder; E0-extended codes never match.
module keycode_to_hole
    import whack_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       ext_i,
    output logic       is_digit_o,
    output hole_t      hole_o
);

    always_comb begin
        is_digit_o = 1'b1;
        hole_o     = '0;
        case (code_i)
            KeyRow0, KeyPad0: hole_o = 4'd0;
            KeyRow1, KeyPad1: hole_o = 4'd1;
            KeyRow2, KeyPad2: hole_o = 4'd2;
            KeyRow3, KeyPad3: hole_o = 4'd3;
            KeyRow4, KeyPad4: hole_o = 4'd4;
            KeyRow5, KeyPad5: hole_o = 4'd5;
            KeyRow6, KeyPad6: hole_o = 4'd6;
            KeyRow7, KeyPad7: hole_o = 4'd7;
            KeyRow8, KeyPad8: hole_o = 4'd8;
            KeyRow9, KeyPad9: hole_o = 4'd9;
            default:          is_digit_o = 1'b0;
        endcase
        if (ext_i) begin
            is_digit_o = 1'b0;
        end
    end

endmodule

// File: rtl/whack_judge.sv
// Two-stage hit/miss judge: stage 1 decodes the key and filters typematic repeats,
// stage 2 compares against the lit moles and updates whacked mask and streak.
module whack_judge
    import whack_pkg::hole_t;
#(
    parameter int unsigned NUM_HOLES  = whack_pkg::NUM_HOLES,
    parameter int unsigned STREAK_MAX = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [8:0]           last_change,
    input  logic                 key_is_down,
    input  logic                 play_en,
    input  logic                 clear,
    input  logic [NUM_HOLES-1:0] mole,
    output logic                 hit,
    output logic                 miss,
    output hole_t                hole_idx,
    output logic [NUM_HOLES-1:0] whacked,
    output logic [3:0]           streak
);

    localparam logic [3:0] StreakMax = 4'(STREAK_MAX);

    logic  dec_digit;
    hole_t dec_hole;

    keycode_to_hole u_keycode_to_hole (
        .code_i     (last_change[7:0]),
        .ext_i      (last_change[8]),
        .is_digit_o (dec_digit),
        .hole_o     (dec_hole)
    );

    logic [NUM_HOLES-1:0] held_d, held_q;
    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_make_d, s1_make_q;
    logic                 s1_fresh_d, s1_fresh_q;
    hole_t                s1_hole_d, s1_hole_q;

    // Stage 1: freshness is checked against held_q, so a same-hole make in the
    // very next cycle already sees the press recorded.
    always_comb begin
        held_d     = held_q;
        s1_valid_d = key_valid & dec_digit;
        s1_make_d  = key_is_down;
        s1_fresh_d = key_is_down & ~held_q[dec_hole];
        s1_hole_d  = dec_hole;
        if (s1_valid_d) begin
            held_d[dec_hole] = key_is_down;
        end
    end

    logic                 hit_d, hit_q;
    logic                 miss_d, miss_q;
    hole_t                hole_idx_d, hole_idx_q;
    logic [NUM_HOLES-1:0] whacked_d, whacked_q;
    logic [3:0]           streak_d, streak_q;
    logic                 judge;
    logic                 lit;
    logic [NUM_HOLES-1:0] strike_mask;

    always_comb begin
        judge       = s1_valid_q & s1_make_q & s1_fresh_q & play_en;
        lit         = mole[s1_hole_q] & ~whacked_q[s1_hole_q];
        hit_d       = judge & lit;
        miss_d      = judge & ~lit;
        strike_mask = '0;
        if (hit_d) begin
            strike_mask[s1_hole_q] = 1'b1;
        end
        // Masking with mole last makes clearing win over a same-cycle strike
        whacked_d  = (whacked_q | strike_mask) & mole;
        streak_d   = streak_q;
        hole_idx_d = hole_idx_q;
        if (judge) begin
            hole_idx_d = s1_hole_q;
            if (lit) begin
                streak_d = (streak_q >= StreakMax) ? StreakMax : streak_q + 4'd1;
            end else begin
                streak_d = '0;
            end
        end
        if (clear) begin
            streak_d   = '0;
            whacked_d  = '0;
            hole_idx_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_make_q  <= 1'b0;
            s1_fresh_q <= 1'b0;
            s1_hole_q  <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            hole_idx_q <= '0;
            whacked_q  <= '0;
            streak_q   <= '0;
        end else begin
            held_q     <= held_d;
            s1_valid_q <= s1_valid_d;
            s1_make_q  <= s1_make_d;
            s1_fresh_q <= s1_fresh_d;
            s1_hole_q  <= s1_hole_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            hole_idx_q <= hole_idx_d;
            whacked_q  <= whacked_d;
            streak_q   <= streak_d;
        end
    end

    assign hit      = hit_q;
    assign miss     = miss_q;
    assign hole_idx = hole_idx_q;
    assign whacked  = whacked_q;
    assign streak   = streak_q;

endmodule

// File: tb/tb_whack_judge.sv
// Scoreboard bench for whack_judge: each judged press pushes its expected outcome,
// checked two cycles later; every other cycle must be pulse-free.
module tb_whack_judge;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [8:0] last_change;
    logic       key_is_down;
    logic       play_en;
    logic       clear;
    logic [9:0] mole;
    logic       hit;
    logic       miss;
    logic [3:0] hole_idx;
    logic [9:0] whacked;
    logic [3:0] streak;

    whack_judge #(
        .NUM_HOLES  (10),
        .STREAK_MAX (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_is_down (key_is_down),
        .play_en     (play_en),
        .clear       (clear),
        .mole        (mole),
        .hit         (hit),
        .miss        (miss),
        .hole_idx    (hole_idx),
        .whacked     (whacked),
        .streak      (streak)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       hit;
        logic       miss;
        logic [3:0] hole;
        logic [3:0] streak;
        logic [9:0] whacked;
    } exp_t;

    exp_t sb[$];

    logic [7:0] row_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pad_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                   8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    logic [9:0] m_held;
    logic [9:0] m_whacked;
    logic [3:0] m_streak;
    logic [3:0] m_hole;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [8:0] lc);
        decode = -1;
        if (!lc[8]) begin
            for (int i = 0; i < 10; i++) begin
                if (row_codes[i] == lc[7:0] || pad_codes[i] == lc[7:0]) decode = i;
            end
        end
    endfunction

    // One key event in one cycle; optional clear or mole drop in the judging cycle.
    task automatic drive_key(input logic [8:0] lc, input logic down,
                             input bit clr_next = 1'b0, input bit drop_next = 1'b0);
        int         h;
        bit         fresh;
        logic [9:0] eff;
        exp_t       e;
        @(posedge clk);
        #1;
        key_valid   = 1'b1;
        last_change = lc;
        key_is_down = down;
        clear       = 1'b0;
        h = decode(lc);
        if (h >= 0) begin
            fresh     = down && !m_held[h];
            m_held[h] = down;
            if (fresh && play_en) begin
                eff = mole;
                if (drop_next) eff[h] = 1'b0;
                e.due  = cyc + 2;
                e.hit  = eff[h] && !m_whacked[h];
                e.miss = !e.hit;
                if (e.hit) begin
                    m_whacked[h] = 1'b1;
                    m_streak = (m_streak == 4'd9) ? 4'd9 : m_streak + 4'd1;
                end else begin
                    m_streak = 4'd0;
                end
                m_hole    = 4'(h);
                m_whacked = m_whacked & eff;
                if (clr_next) begin
                    m_streak  = 4'd0;
                    m_whacked = 10'd0;
                    m_hole    = 4'd0;
                end
                e.hole    = m_hole;
                e.streak  = m_streak;
                e.whacked = m_whacked;
                sb.push_back(e);
            end
        end
        if (clr_next || drop_next) begin
            @(posedge clk);
            #1;
            key_valid = 1'b0;
            clear     = clr_next;
            if (drop_next && h >= 0) mole[h] = 1'b0;
            @(posedge clk);
            #1;
            clear = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            key_valid = 1'b0;
        end
    endtask

    task automatic set_mole(input logic [9:0] v);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        mole      = v;
        m_whacked = m_whacked & v;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (sb.size() != 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check_eq("late_judgement", 32'(cyc), 32'(e.due));
            end
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check_eq("hit", 32'(hit), 32'(e.hit));
                check_eq("miss", 32'(miss), 32'(e.miss));
                check_eq("hole_idx", 32'(hole_idx), 32'(e.hole));
                check_eq("streak", 32'(streak), 32'(e.streak));
                check_eq("whacked", 32'(whacked), 32'(e.whacked));
            end else begin
                check_eq("no_pulse", 32'({hit, miss}), 32'd0);
            end
        end
    end

    initial begin
        int         h;
        logic [7:0] code;

        rst         = 1'b1;
        key_valid   = 1'b0;
        last_change = 9'd0;
        key_is_down = 1'b0;
        play_en     = 1'b0;
        clear       = 1'b0;
        mole        = 10'd0;
        m_held      = 10'd0;
        m_whacked   = 10'd0;
        m_streak    = 4'd0;
        m_hole      = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hit", 32'(hit), 32'd0);
        check_eq("rst_miss", 32'(miss), 32'd0);
        check_eq("rst_hole_idx", 32'(hole_idx), 32'd0);
        check_eq("rst_whacked", 32'(whacked), 32'd0);
        check_eq("rst_streak", 32'(streak), 32'd0);
        rst     = 1'b0;
        play_en = 1'b1;

        // Basic hit on hole 3, then a re-press of the still-whacked hole misses
        set_mole(10'b0000001000);
        drive_key(9'h026, 1'b1);
        idle(3);
        drive_key(9'h026, 1'b0);
        drive_key(9'h026, 1'b1);
        idle(3);
        set_mole(10'd0);
        @(negedge clk);
        check_eq("whacked_before_clr", 32'(whacked), 32'h008);
        @(negedge clk);
        check_eq("whacked_after_clr", 32'(whacked), 32'h000);

        // Typematic repeats of keypad 2 give a single hit
        set_mole(10'b0000000100);
        repeat (5) drive_key(9'h072, 1'b1);
        drive_key(9'h072, 1'b0);
        idle(3);

        // Twelve hits alternating holes 0 and 1, row and keypad codes
        for (int i = 0; i < 12; i++) begin
            h    = i % 2;
            code = ((i % 4) < 2) ? row_codes[h] : pad_codes[h];
            set_mole(10'b1 << h);
            drive_key({1'b0, code}, 1'b1);
            drive_key({1'b0, code}, 1'b0);
            idle(2);
        end
        @(negedge clk);
        check_eq("streak_saturated", 32'(streak), 32'd9);
        set_mole(10'd0);
        drive_key(9'h025, 1'b1);
        drive_key(9'h025, 1'b0);
        idle(3);
        @(negedge clk);
        check_eq("streak_after_miss", 32'(streak), 32'd0);

        // No judgement while not playing, nor for non-digit / extended codes
        set_mole(10'b0000000010);
        play_en = 1'b0;
        drive_key(9'h016, 1'b1);
        drive_key(9'h016, 1'b0);
        idle(3);
        play_en = 1'b1;
        drive_key(9'h01C, 1'b1);
        drive_key(9'h170, 1'b1);
        idle(3);
        drive_key(9'h01C, 1'b0);
        drive_key(9'h170, 1'b0);
        idle(2);

        // Mole falls in the judging cycle: miss
        set_mole(10'b0000010000);
        drive_key(9'h025, 1'b1, 1'b0, 1'b1);
        drive_key(9'h025, 1'b0);
        idle(3);

        // Clear coincident with a hit wins over streak/whacked/hole_idx
        set_mole(10'b0000100000);
        drive_key(9'h02E, 1'b1);
        drive_key(9'h02E, 1'b0);
        idle(2);
        set_mole(10'b0001100000);
        drive_key(9'h036, 1'b1, 1'b1, 1'b0);
        idle(3);
        @(negedge clk);
        check_eq("clear_streak", 32'(streak), 32'd0);
        check_eq("clear_whacked", 32'(whacked), 32'd0);

        // Reset while stage 1 holds a press for a lit hole
        set_mole(10'b0010000000);
        @(posedge clk);
        #1;
        key_valid   = 1'b1;
        last_change = 9'h03D;
        key_is_down = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        rst       = 1'b1;
        m_held    = 10'd0;
        m_whacked = 10'd0;
        m_streak  = 4'd0;
        m_hole    = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_hit", 32'(hit), 32'd0);
        check_eq("post_rst_miss", 32'(miss), 32'd0);
        check_eq("post_rst_hole_idx", 32'(hole_idx), 32'd0);
        check_eq("post_rst_whacked", 32'(whacked), 32'd0);
        check_eq("post_rst_streak", 32'(streak), 32'd0);
        idle(4);
        // held was cleared by reset, so the same key is fresh again
        drive_key(9'h03D, 1'b1);
        idle(3);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
